// File: rtl/bsc_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : bsc_dbus_responder
// Description : Bus state controller slice acting as responder on the DBUS.
//               Decodes four chip-select areas from A[26:25], runs an external
//               memory cycle (T1, optional TW states, T2) with programmable
//               plus external wait states, returns registered read data, and
//               hands the external bus to an external master (HIZ) unless
//               DBUS_LOCK holds it between cycles.
// Ports       : clk/rst_n         - clock, async active-low reset
//               i_ce_r / i_ce_f   - rising / falling phase enables
//               i_dbus_*          - request side (address, data, lanes, we,
//                                   req, lock)
//               o_dbus_di         - registered read data
//               o_dbus_wait       - stall to initiator
//               o_bsc_ack         - high in the T2 state of every cycle
//               o_mem_* / i_mem_* - external memory bus
//               i_breq_n/o_back_n - external master request / grant
// Revision    : 1.0 - initial release
// ============================================================================
module bsc_dbus_responder #(
    parameter int AW0 = 0,
    parameter int AW1 = 1,
    parameter int AW2 = 2,
    parameter int AW3 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ce_r,
    input  logic        i_ce_f,
    input  logic [31:0] i_dbus_a,
    input  logic [31:0] i_dbus_do,
    input  logic [3:0]  i_dbus_ba,
    input  logic        i_dbus_we,
    input  logic        i_dbus_req,
    input  logic        i_dbus_lock,
    output logic [31:0] o_dbus_di,
    output logic        o_dbus_wait,
    output logic        o_bsc_ack,
    output logic [26:0] o_mem_a,
    output logic [31:0] o_mem_do,
    input  logic [31:0] i_mem_di,
    output logic [3:0]  o_mem_cs_n,
    output logic        o_mem_rd_n,
    output logic [3:0]  o_mem_we_n,
    input  logic        i_mem_wait_n,
    output logic        o_mem_oe,
    input  logic        i_breq_n,
    output logic        o_back_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_TW   = 3'd2,
        S_T2   = 3'd3,
        S_HIZ  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_load;
    logic        w_active;
    logic [2:0]  w_aw_sel;

    logic [26:0] r_mem_a;
    logic [31:0] r_mem_do;
    logic [31:0] r_dbus_di;
    logic        r_we;
    logic [3:0]  r_ba;
    logic [2:0]  r_cnt;

    // CE_F and the upper address bits are not needed by this slice.
    logic        w_unused;
    assign w_unused = ^{i_ce_f, i_dbus_a[31:27]};

    // Programmed wait count for the area of the incoming request.
    always_comb begin
        w_aw_sel = 3'd0;
        case (i_dbus_a[26:25])
            2'd0:    w_aw_sel = 3'(AW0);
            2'd1:    w_aw_sel = 3'(AW1);
            2'd2:    w_aw_sel = 3'(AW2);
            default: w_aw_sel = 3'(AW3);
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                // No lock can be held in IDLE, so a bus request wins.
                if (!i_breq_n) begin
                    w_next = S_HIZ;
                end else if (i_dbus_req) begin
                    w_next = S_T1;
                    w_load = 1'b1;
                end
            end
            S_T1: begin
                w_next = (r_cnt != 3'd0) ? S_TW : S_T2;
            end
            S_TW: begin
                // External wait is only honoured on the last programmed TW.
                if (r_cnt <= 3'd1 && i_mem_wait_n) begin
                    w_next = S_T2;
                end
            end
            S_T2: begin
                if (!i_breq_n && !i_dbus_lock) begin
                    w_next = S_HIZ;
                end else if (i_dbus_req) begin
                    w_next = S_T1;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_HIZ: begin
                if (i_breq_n) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_active    = (r_state == S_T1) || (r_state == S_TW) || (r_state == S_T2);
    assign o_mem_cs_n  = w_active ? ~(4'b0001 << r_mem_a[26:25]) : 4'hF;
    assign o_mem_rd_n  = !(w_active && !r_we);
    assign o_mem_we_n  = (w_active && r_we) ? ~r_ba : 4'hF;
    assign o_mem_oe    = (r_state != S_HIZ);
    assign o_back_n    = (r_state != S_HIZ);
    assign o_bsc_ack   = (r_state == S_T2);
    // Gated by reset so the stall drops as soon as a cycle is aborted.
    assign o_dbus_wait = rst_n && i_dbus_req && (r_state != S_T2);
    assign o_mem_a     = r_mem_a;
    assign o_mem_do    = r_mem_do;
    assign o_dbus_di   = r_dbus_di;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (i_ce_r) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_a   <= 27'd0;
            r_mem_do  <= 32'd0;
            r_dbus_di <= 32'd0;
            r_we      <= 1'b0;
            r_ba      <= 4'd0;
            r_cnt     <= 3'd0;
        end else if (i_ce_r) begin
            if (w_load) begin
                r_mem_a  <= i_dbus_a[26:0];
                r_mem_do <= i_dbus_do;
                r_we     <= i_dbus_we;
                r_ba     <= i_dbus_ba;
                r_cnt    <= w_aw_sel;
            end else if (r_state == S_TW && r_cnt > 3'd1) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Read data is sampled on the edge that enters T2.
            if (w_next == S_T2 && r_state != S_T2 && !r_we) begin
                r_dbus_di <= i_mem_di;
            end
        end
    end

endmodule
`default_nettype wire
